// File: rtl/street_light_ctrl.sv
// Street-light / pedestrian-crossing controller: a self-running Moore FSM with
// a phase timer, synchronised button latch and registered lamp drivers.
module street_light_ctrl #(
  parameter int unsigned GREEN_MIN  = 20,
  parameter int unsigned YELLOW_T   = 4,
  parameter int unsigned ALLRED_T   = 2,
  parameter int unsigned WALK_T     = 10,
  parameter int unsigned FLASH_T    = 6,
  parameter int unsigned FLASH_HALF = 1,
  parameter int unsigned TW         = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       b,
  output logic [2:0] state,
  output logic       timer,
  output logic       req_pending,
  output logic       Light,
  output logic       Light2,
  output logic       Light3,
  output logic       Light4
);

  typedef enum logic [2:0] {
    MAIN_GREEN  = 3'b000,
    MAIN_YELLOW = 3'b001,
    ALL_RED1    = 3'b010,
    WALK        = 3'b011,
    WALK_FLASH  = 3'b100,
    ALL_RED2    = 3'b101
  } state_e;

  localparam logic [TW-1:0] GREEN_LD  = TW'(GREEN_MIN - 32'd1);
  localparam logic [TW-1:0] YELLOW_LD = TW'(YELLOW_T - 32'd1);
  localparam logic [TW-1:0] ALLRED_LD = TW'(ALLRED_T - 32'd1);
  localparam logic [TW-1:0] WALK_LD   = TW'(WALK_T - 32'd1);
  localparam logic [TW-1:0] FLASH_LD  = TW'(FLASH_T - 32'd1);
  localparam logic [TW-1:0] FHALF_LD  = TW'(FLASH_HALF - 32'd1);
  localparam logic [TW-1:0] CNT_ZERO  = {TW{1'b0}};
  localparam logic [TW-1:0] CNT_ONE   = {{(TW-1){1'b0}}, 1'b1};

  // Lamp vector {Light, Light2, Light3, Light4}; illegal codes show all-red.
  function automatic logic [3:0] lamps_f(input state_e s, input logic flash);
    case (s)
      MAIN_GREEN:  lamps_f = 4'b1000;
      MAIN_YELLOW: lamps_f = 4'b0100;
      WALK:        lamps_f = 4'b0011;
      WALK_FLASH:  lamps_f = {3'b001, flash};
      default:     lamps_f = 4'b0010;
    endcase
  endfunction

  state_e          state_q, state_d;
  logic [TW-1:0]   cnt_q, cnt_d;
  logic [TW-1:0]   fcnt_q, fcnt_d;
  logic            flash_q, flash_d;
  logic            sync1_q, sync2_q, sync3_q;
  logic            req_q, req_d;
  logic            timer_q;
  logic [3:0]      lamps_q;
  logic            timer_s;
  logic            rise_s;
  logic            enter_walk_s;
  logic            req_window_s;

  assign timer_s      = (cnt_q == CNT_ZERO);
  assign rise_s       = sync2_q & ~sync3_q;
  assign enter_walk_s = (state_q == ALL_RED1) && timer_s;
  assign req_window_s = (state_q == MAIN_GREEN) || (state_q == MAIN_YELLOW) ||
                        (state_q == ALL_RED1)   || (state_q == ALL_RED2);

  // Next-state, phase counter and flash sequencing.
  always_comb begin
    state_d = state_q;
    flash_d = flash_q;
    fcnt_d  = fcnt_q;
    if (cnt_q != CNT_ZERO) begin
      cnt_d = cnt_q - CNT_ONE;
    end else begin
      cnt_d = cnt_q;
    end
    case (state_q)
      MAIN_GREEN: begin
        if (timer_s && req_q) begin
          state_d = MAIN_YELLOW;
          cnt_d   = YELLOW_LD;
        end else begin
          state_d = MAIN_GREEN;
        end
      end
      MAIN_YELLOW: begin
        if (timer_s) begin
          state_d = ALL_RED1;
          cnt_d   = ALLRED_LD;
        end else begin
          state_d = MAIN_YELLOW;
        end
      end
      ALL_RED1: begin
        if (timer_s) begin
          state_d = WALK;
          cnt_d   = WALK_LD;
        end else begin
          state_d = ALL_RED1;
        end
      end
      WALK: begin
        if (timer_s) begin
          state_d = WALK_FLASH;
          cnt_d   = FLASH_LD;
          flash_d = 1'b1;
          fcnt_d  = FHALF_LD;
        end else begin
          state_d = WALK;
        end
      end
      WALK_FLASH: begin
        if (fcnt_q == CNT_ZERO) begin
          flash_d = ~flash_q;
          fcnt_d  = FHALF_LD;
        end else begin
          fcnt_d  = fcnt_q - CNT_ONE;
        end
        if (timer_s) begin
          state_d = ALL_RED2;
          cnt_d   = ALLRED_LD;
          flash_d = 1'b0;
          fcnt_d  = CNT_ZERO;
        end else begin
          state_d = WALK_FLASH;
        end
      end
      ALL_RED2: begin
        if (timer_s) begin
          state_d = MAIN_GREEN;
          cnt_d   = GREEN_LD;
        end else begin
          state_d = ALL_RED2;
        end
      end
      default: begin
        state_d = ALL_RED2;
        cnt_d   = ALLRED_LD;
        flash_d = 1'b0;
        fcnt_d  = CNT_ZERO;
      end
    endcase
  end

  // Request latch: clearing on WALK entry beats a coincident button rise.
  always_comb begin
    if (enter_walk_s) begin
      req_d = 1'b0;
    end else if (rise_s && req_window_s) begin
      req_d = 1'b1;
    end else begin
      req_d = req_q;
    end
  end

  // State, counters, button synchroniser and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= MAIN_GREEN;
      cnt_q   <= GREEN_LD;
      fcnt_q  <= CNT_ZERO;
      flash_q <= 1'b0;
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
      req_q   <= 1'b0;
      timer_q <= (GREEN_MIN == 32'd1);
      lamps_q <= 4'b1000;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fcnt_q  <= fcnt_d;
      flash_q <= flash_d;
      sync1_q <= b;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
      req_q   <= req_d;
      timer_q <= (cnt_d == CNT_ZERO);
      lamps_q <= lamps_f(state_d, flash_d);
    end
  end

  assign state       = state_q;
  assign timer       = timer_q;
  assign req_pending = req_q;
  assign Light       = lamps_q[3];
  assign Light2      = lamps_q[2];
  assign Light3      = lamps_q[1];
  assign Light4      = lamps_q[0];

endmodule
